// File: rtl/morse_decoder.sv
// Morse symbol assembler: dot/dash pulses -> ASCII characters, word gaps -> one space.
// Define MORSE_DIGITS_EN to add the five-symbol digits 0-9 to the decode table.
module morse_decoder #(
  parameter int LETTER_GAP = 8,
  parameter int WORD_GAP   = 20,
  parameter int GAP_W      = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       dot_i,
  input  logic       dash_i,
  output logic [7:0] letter_o,
  output logic       letter_valid_o,
  output logic       error_o,
  output logic       busy_o
);

`ifdef MORSE_DIGITS_EN
  localparam logic [2:0] MAXLEN = 3'd5;
`else
  localparam logic [2:0] MAXLEN = 3'd4;
`endif
  localparam logic [GAP_W-1:0] LG  = GAP_W'(LETTER_GAP);
  localparam logic [GAP_W-1:0] WG  = GAP_W'(WORD_GAP);
  localparam logic [GAP_W-1:0] ONE = GAP_W'(1);

  // Returns {hit, ascii}; code holds the newest symbol in the LSB, dash = 1.
  function automatic logic [8:0] morse_lookup(input logic [2:0] len, input logic [4:0] code);
    logic [8:0] r;
    case ({len, code})
      8'b001_00000: r = {1'b1, 8'h45}; // E
      8'b001_00001: r = {1'b1, 8'h54}; // T
      8'b010_00000: r = {1'b1, 8'h49}; // I
      8'b010_00001: r = {1'b1, 8'h41}; // A
      8'b010_00010: r = {1'b1, 8'h4E}; // N
      8'b010_00011: r = {1'b1, 8'h4D}; // M
      8'b011_00000: r = {1'b1, 8'h53}; // S
      8'b011_00001: r = {1'b1, 8'h55}; // U
      8'b011_00010: r = {1'b1, 8'h52}; // R
      8'b011_00011: r = {1'b1, 8'h57}; // W
      8'b011_00100: r = {1'b1, 8'h44}; // D
      8'b011_00101: r = {1'b1, 8'h4B}; // K
      8'b011_00110: r = {1'b1, 8'h47}; // G
      8'b011_00111: r = {1'b1, 8'h4F}; // O
      8'b100_00000: r = {1'b1, 8'h48}; // H
      8'b100_00001: r = {1'b1, 8'h56}; // V
      8'b100_00010: r = {1'b1, 8'h46}; // F
      8'b100_00100: r = {1'b1, 8'h4C}; // L
      8'b100_00110: r = {1'b1, 8'h50}; // P
      8'b100_00111: r = {1'b1, 8'h4A}; // J
      8'b100_01000: r = {1'b1, 8'h42}; // B
      8'b100_01001: r = {1'b1, 8'h58}; // X
      8'b100_01010: r = {1'b1, 8'h43}; // C
      8'b100_01011: r = {1'b1, 8'h59}; // Y
      8'b100_01100: r = {1'b1, 8'h5A}; // Z
      8'b100_01101: r = {1'b1, 8'h51}; // Q
`ifdef MORSE_DIGITS_EN
      8'b101_00000: r = {1'b1, 8'h35};
      8'b101_00001: r = {1'b1, 8'h34};
      8'b101_00011: r = {1'b1, 8'h33};
      8'b101_00111: r = {1'b1, 8'h32};
      8'b101_01111: r = {1'b1, 8'h31};
      8'b101_11111: r = {1'b1, 8'h30};
      8'b101_11110: r = {1'b1, 8'h39};
      8'b101_11100: r = {1'b1, 8'h38};
      8'b101_11000: r = {1'b1, 8'h37};
      8'b101_10000: r = {1'b1, 8'h36};
`endif
      default:      r = 9'h000;
    endcase
    return r;
  endfunction

  logic [4:0]       code_q, code_d;
  logic [2:0]       len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             spc_armed_q, spc_armed_d;
  logic [7:0]       letter_q, letter_d;
  logic             letter_valid_q, letter_valid_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic [GAP_W-1:0] gap_inc_s;
  logic [8:0]       lookup_s;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_q         <= 5'd0;
      len_q          <= 3'd0;
      ovf_q          <= 1'b0;
      gap_q          <= '0;
      spc_armed_q    <= 1'b0;
      letter_q       <= 8'h00;
      letter_valid_q <= 1'b0;
      error_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      code_q         <= code_d;
      len_q          <= len_d;
      ovf_q          <= ovf_d;
      gap_q          <= gap_d;
      spc_armed_q    <= spc_armed_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      error_q        <= error_d;
      busy_q         <= busy_d;
    end
  end

  // Next state: symbol append has priority over character close and space emission
  always_comb begin
    code_d         = code_q;
    len_d          = len_q;
    ovf_d          = ovf_q;
    gap_d          = gap_q;
    spc_armed_d    = spc_armed_q;
    letter_d       = letter_q;
    letter_valid_d = 1'b0;
    error_d        = 1'b0;
    gap_inc_s      = (&gap_q) ? gap_q : gap_q + ONE;
    lookup_s       = morse_lookup(len_q, code_q);

    if (dot_i ^ dash_i) begin
      code_d = {code_q[3:0], dash_i};
      if (len_q < MAXLEN) begin
        len_d = len_q + 3'd1;
      end else begin
        ovf_d = 1'b1;
      end
      gap_d = '0;
    end else if (dot_i & dash_i) begin
      ovf_d = 1'b1;
      gap_d = '0;
    end else begin
      gap_d = gap_inc_s;
      // A lone violation (ovf with no symbols) also closes, so busy never sticks.
      if ((gap_inc_s == LG) && ((len_q != 3'd0) || ovf_q)) begin
        if (lookup_s[8] && !ovf_q) begin
          letter_d       = lookup_s[7:0];
          letter_valid_d = 1'b1;
          spc_armed_d    = 1'b1;
        end else begin
          error_d = 1'b1;
        end
        code_d = 5'd0;
        len_d  = 3'd0;
        ovf_d  = 1'b0;
      end else if ((gap_inc_s == WG) && spc_armed_q) begin
        letter_d       = 8'h20;
        letter_valid_d = 1'b1;
        spc_armed_d    = 1'b0;
      end else begin
        spc_armed_d = spc_armed_q;
      end
    end
    busy_d = (len_d != 3'd0) | ovf_d;
  end

  // Outputs come straight from registers
  always_comb begin
    letter_o       = letter_q;
    letter_valid_o = letter_valid_q;
    error_o        = error_q;
    busy_o         = busy_q;
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: stimulus pushes expected strobes, a monitor pops and compares.
module tb_morse_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dot = 1'b0;
  logic       dash = 1'b0;
  logic [7:0] letter;
  logic       letter_valid;
  logic       error;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] ch;
    int         at;
  } exp_t;
  exp_t q[$];

  morse_decoder #(.LETTER_GAP(8), .WORD_GAP(20), .GAP_W(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dot_i(dot), .dash_i(dash),
    .letter_o(letter), .letter_valid_o(letter_valid), .error_o(error), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // s: 0 = dot, 1 = dash, 2 = both; called at a negedge, returns the sampling edge index
  task automatic send(input int s, output int e);
    dot  = (s != 1);
    dash = (s != 0);
    @(negedge clk);
    dot  = 1'b0;
    dash = 1'b0;
    e    = cyc;
  endtask

  task automatic push(input bit is_err, input logic [7:0] ch, input int at);
    exp_t x;
    x.is_err = is_err;
    x.ch     = ch;
    x.at     = at;
    q.push_back(x);
  endtask

  // Monitor: every strobe must match the oldest expectation, including its edge
  always @(negedge clk) begin
    if (rst_n && (letter_valid || error)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: valid=%0b error=%0b letter=%02h at edge %0d, expected none",
                 letter_valid, error, letter, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ((error != e.is_err) || (letter_valid != !e.is_err) || (letter != e.ch) || (cyc != e.at)) begin
          fails++;
          $display("FAIL strobe: got valid=%0b error=%0b letter=%02h edge=%0d, expected valid=%0b error=%0b letter=%02h edge=%0d",
                   letter_valid, error, letter, cyc, !e.is_err, e.is_err, e.ch, e.at);
        end
      end
    end
  end

  initial begin
    int e;
    int e0;
    repeat (2) @(negedge clk);
    chk("reset_letter", int'(letter), 8'h00);
    chk("reset_valid", int'(letter_valid), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);

    // "A" then a word gap space
    send(0, e);
    chk("busy_after_dot", int'(busy), 1);
    send(1, e);
    push(1'b0, 8'h41, e + 8);
    push(1'b0, 8'h20, e + 20);
    repeat (8) @(negedge clk);
    chk("busy_after_close", int'(busy), 0);
    repeat (17) @(negedge clk);

    // "B", one space, then a long silence with nothing more
    send(1, e); send(0, e); send(0, e); send(0, e);
    push(1'b0, 8'h42, e + 8);
    push(1'b0, 8'h20, e + 20);
    repeat (40) @(negedge clk);

    // ".-.-" is not in the table; letter keeps the space
    send(0, e); send(1, e); send(0, e); send(1, e);
    push(1'b1, 8'h20, e + 8);
    repeat (25) @(negedge clk);
    chk("letter_held_after_error", int'(letter), 8'h20);

    // Five dots
    repeat (5) send(0, e);
`ifdef MORSE_DIGITS_EN
    push(1'b0, 8'h35, e + 8);
    push(1'b0, 8'h20, e + 20);
`else
    push(1'b1, 8'h20, e + 8);
`endif
    repeat (25) @(negedge clk);

    // Dot followed by a both-high violation
    send(0, e);
    send(2, e);
    chk("busy_after_violation", int'(busy), 1);
    push(1'b1, 8'h20, e + 8);
    repeat (25) @(negedge clk);

    // Dash lands on the edge that would close the lone dot
    send(0, e0);
    repeat (7) @(negedge clk);
    send(1, e);
    chk("dash_edge_offset", e - e0, 8);
    push(1'b0, 8'h41, e + 8);
    push(1'b0, 8'h20, e + 20);
    repeat (25) @(negedge clk);

    // Reset mid-character drops it silently
    send(0, e); send(0, e);
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("busy_in_reset", int'(busy), 0);
    chk("letter_in_reset", int'(letter), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    chk("pending_expectations", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/morse_decoder.md
# morse_decoder

Consumes the one-cycle `dot` / `dash` pulses produced by the input parser stage and assembles them into Morse characters. Character boundaries come from inter-symbol silence measured in clock cycles. Each recognised character is emitted as a one-cycle ASCII strobe, and word gaps emit a single space. Sits directly downstream of the input parser, feeding the display/character sink.

## Interface
- `LETTER_GAP`, default 8: idle clock edges after the last symbol that close a character; must be ≥ 2.
- `WORD_GAP`, default 20: idle clock edges after the last symbol that emit a space; must be > `LETTER_GAP`.
- `GAP_W`, default 10: gap counter width; must satisfy 2^`GAP_W` − 1 ≥ `WORD_GAP`.
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `dot`  in  1  one-cycle pulse, dot symbol completed.
- `dash`  in  1  one-cycle pulse, dash symbol completed.
- `letter`  out  8  ASCII code of the decoded character or space; holds its value between strobes.
- `letter_valid`  out  1  one-cycle strobe, `letter` is new.
- `error`  out  1  one-cycle strobe, character discarded.
- `busy`  out  1  high while at least one symbol is buffered.

## Operation
- State: `code[4:0]` symbol shift register (dot=0, dash=1, newest in LSB), `len[2:0]`, `ovf` flag, `gap[GAP_W-1:0]`, `spc_armed` flag.
- Symbol edge (`dot` xor `dash` sampled high):
  - `code` ← {`code[3:0]`, `dash`}.
  - If `len` < MAXLEN, then `len`++; otherwise set `ovf`.
  - `gap` ← 0.
- `dot` and `dash` both high in the same cycle: treat as a violation. Do not shift; set `ovf`; `gap` ← 0.
- Idle edge: `gap` increments, saturating at all-ones.
- Character close, when the incremented `gap` equals `LETTER_GAP` and `len` ≠ 0:
  - Look up (`len`, `code`) in the table of A–Z and, with the macro, 0–9.
  - Hit with `ovf` clear: `letter` ← ASCII uppercase or digit, `letter_valid` = 1, `spc_armed` ← 1.
  - Miss, or `ovf` set: `error` = 1; `letter` is unchanged.
  - In both cases clear `len`, `code`, `ovf`.
- Space, when the incremented `gap` equals `WORD_GAP` and `spc_armed`=1: `letter` ← 0x20, `letter_valid` = 1, `spc_armed` ← 0. At most one space is emitted per silence.
- `busy` = (`len` ≠ 0) | `ovf`.
- A symbol arriving on the same edge that would close a character takes priority: it appends and resets `gap`; no close happens that cycle.
- `letter_valid` and `error` are never high in the same cycle.

## Timing
- Reset values:
  - `letter`=0x00, `letter_valid`=0, `error`=0, `busy`=0.
  - `code`=0, `len`=0, `ovf`=0, `gap`=0, `spc_armed`=0.
- Reset asserted mid-character drops the partial character silently; no strobe is emitted.
- All outputs are registered.
- Take the edge that samples the last symbol pulse as edge 0. Then `letter_valid`/`error` is visible after edge `LETTER_GAP`, and the space strobe after edge `WORD_GAP`.
- Back-to-back symbol pulses on consecutive cycles are accepted; there is no backpressure.
- The sink must consume `letter` in the strobe cycle.

## Configuration
- `MORSE_DIGITS_EN` defined:
  - MAXLEN = 5.
  - The table includes digits 0–9 (five-symbol codes, e.g. "....." → 0x35).
- `MORSE_DIGITS_EN` undefined:
  - MAXLEN = 4; only A–Z decode.
  - A 5th symbol sets `ovf`, so the character ends in `error`.

## Test plan
- Reset low for 2 cycles, then release: all outputs 0, `busy`=0.
- Dot, dash, then idle (default params): `busy`=1 after the first pulse. After edge 8: `letter`=0x41, `letter_valid`=1 for one cycle, `busy`=0.
- Dash, dot, dot, dot: `letter`=0x42 ('B'). Continue idle to edge 20: `letter`=0x20 once. Idle to edge 40: no further strobe.
- Dot, dash, dot, dash (".-.-"): `error`=1 at edge 8, `letter_valid` stays 0, `letter` keeps its previous value.
- Five dots: with `MORSE_DIGITS_EN` → `letter`=0x35; without → `error`=1. Separately, `dot` and `dash` high together → `error` at close.
- Dot, then wait 7 idle edges, then dash: no strobe at edge 8; 'A' is emitted 8 edges after the dash. Separately, reset asserted after two symbols → no strobe at all, and `busy`=0 immediately.
